game_next_gen_engine: RTL and testbench

//  Computes the next Conway generation from the current field and hands it to the field register.
//  - Upstream: the step tick source.
//  - Downstream: the field register, which latches game_field_new on new_game_field_vld and returns it as game_field_old.
//  - Sequential, one row per cycle, so only one row of rule logic is built.

---
 rtl/game_pkg.sv | 17 +
 rtl/game_row_rule.sv | 57 +++++
 rtl/game_next_gen_engine.sv | 158 +++++++++++++++
 tb/tb_game_next_gen_engine.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types for the Conway next-generation engine: field geometry,
// row/field containers and the generation FSM states.
package game_pkg;

    localparam int FIELD_W = 40;
    localparam int FIELD_H = 30;

    typedef logic [FIELD_W-1:0] row_t;
    typedef row_t [FIELD_H-1:0] field_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } gen_state_t;

endpackage

// File: rtl/game_row_rule.sv
// Combinational Conway rule for one row: counts the eight neighbours of
// every cell from the rows above/current/below and applies B3/S23.
module game_row_rule #(
    parameter int W    = 40,
    parameter int WRAP = 1
) (
    input  logic [W-1:0] i_row_above,
    input  logic [W-1:0] i_row_cur,
    input  logic [W-1:0] i_row_below,
    output logic [W-1:0] o_row_next
);

    // Pad a row with the column -1 cell in bit 0 and the column W cell in
    // bit W+1, so cell c always sits at bit c+1 of the extended row.
    function automatic logic [W+1:0] edge_extend(input logic [W-1:0] row);
        logic lo;
        logic hi;
        if (WRAP != 0) begin
            lo = row[W-1];
            hi = row[0];
        end else begin
            lo = 1'b0;
            hi = 1'b0;
        end
        return {hi, row, lo};
    endfunction

    // Neighbour count: three cells above, three below, two beside.
    function automatic logic [3:0] sum8(input logic [2:0] a,
                                        input logic [2:0] b,
                                        input logic [1:0] m);
        return {3'b000, a[0]} + {3'b000, a[1]} + {3'b000, a[2]} +
               {3'b000, b[0]} + {3'b000, b[1]} + {3'b000, b[2]} +
               {3'b000, m[0]} + {3'b000, m[1]};
    endfunction

    logic [W+1:0] w_ext_above;
    logic [W+1:0] w_ext_cur;
    logic [W+1:0] w_ext_below;
    logic [3:0]   w_cnt [W];

    assign w_ext_above = edge_extend(i_row_above);
    assign w_ext_cur   = edge_extend(i_row_cur);
    assign w_ext_below = edge_extend(i_row_below);

    // Per-cell neighbour count and birth/survival decision.
    always_comb begin
        o_row_next = '0;
        for (int c = 0; c < W; c++) begin
            w_cnt[c] = sum8(w_ext_above[c +: 3], w_ext_below[c +: 3],
                            {w_ext_cur[c + 2], w_ext_cur[c]});
            o_row_next[c] = (w_cnt[c] == 4'd3) |
                            (w_ext_cur[c + 1] & (w_cnt[c] == 4'd2));
        end
    end

endmodule

// File: rtl/game_next_gen_engine.sv
// Sequential Conway next-generation engine: evaluates one row per cycle
// into a holding buffer, then strobes the finished field downstream.
module game_next_gen_engine
    import game_pkg::*;
#(
    parameter int W    = FIELD_W,
    parameter int H    = FIELD_H,
    parameter int WRAP = 1,
    parameter int GW   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  step_req,
    input  logic [H-1:0][W-1:0]   game_field_old,
    output logic [H-1:0][W-1:0]   game_field_new,
    output logic                  new_game_field_vld,
    output logic                  busy,
    output logic [GW-1:0]         gen_count
);

    localparam int             RW       = (H > 1) ? $clog2(H) : 1;
    localparam logic [RW-1:0]  LAST_ROW = RW'(H - 1);

    gen_state_t          r_state;
    gen_state_t          w_state_nxt;
    logic [RW-1:0]       r_row_idx;
    logic [RW-1:0]       w_row_idx_nxt;
    logic                r_pending;
    logic                w_pending_nxt;
    logic                w_row_we;
    logic                r_vld;
    logic                r_busy;
    logic [GW-1:0]       r_gen_count;
    logic [H-1:0][W-1:0] r_field;
    logic [W-1:0]        w_row_above;
    logic [W-1:0]        w_row_cur;
    logic [W-1:0]        w_row_below;
    logic [W-1:0]        w_row_next;

    // Next-state, row counter and request queue decisions.
    always_comb begin
        w_state_nxt   = r_state;
        w_row_idx_nxt = r_row_idx;
        w_pending_nxt = r_pending;
        w_row_we      = 1'b0;
        case (r_state)
            IDLE: begin
                // A request left queued by DONE is consumed here as well.
                if (step_req | r_pending) begin
                    w_state_nxt   = COMPUTE;
                    w_row_idx_nxt = '0;
                    w_pending_nxt = 1'b0;
                end else begin
                    w_state_nxt   = IDLE;
                end
            end
            COMPUTE: begin
                w_row_we = 1'b1;
                if (step_req) begin
                    w_pending_nxt = 1'b1;
                end else begin
                    w_pending_nxt = r_pending;
                end
                if (r_row_idx == LAST_ROW) begin
                    w_state_nxt   = DONE;
                    w_row_idx_nxt = '0;
                end else begin
                    w_row_idx_nxt = r_row_idx + RW'(1);
                end
            end
            DONE: begin
                // The queued request is consumed; a coincident one re-queues.
                w_pending_nxt = step_req;
                w_row_idx_nxt = '0;
                if (r_pending) begin
                    w_state_nxt = COMPUTE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_row_idx_nxt = '0;
                w_pending_nxt = 1'b0;
            end
        endcase
    end

    // Select the three source rows around row_idx, wrapping or zeroing at edges.
    always_comb begin
        w_row_cur = game_field_old[r_row_idx];
        if (r_row_idx == '0) begin
            if (WRAP != 0) begin
                w_row_above = game_field_old[H-1];
            end else begin
                w_row_above = '0;
            end
        end else begin
            w_row_above = game_field_old[r_row_idx - RW'(1)];
        end
        if (r_row_idx == LAST_ROW) begin
            if (WRAP != 0) begin
                w_row_below = game_field_old[0];
            end else begin
                w_row_below = '0;
            end
        end else begin
            w_row_below = game_field_old[r_row_idx + RW'(1)];
        end
    end

    game_row_rule #(
        .W    (W),
        .WRAP (WRAP)
    ) u_row_rule (
        .i_row_above (w_row_above),
        .i_row_cur   (w_row_cur),
        .i_row_below (w_row_below),
        .o_row_next  (w_row_next)
    );

    // FSM state, row counter, pending flag and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_row_idx   <= '0;
            r_pending   <= 1'b0;
            r_vld       <= 1'b0;
            r_busy      <= 1'b0;
            r_gen_count <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_row_idx <= w_row_idx_nxt;
            r_pending <= w_pending_nxt;
            r_vld     <= (w_state_nxt == DONE);
            r_busy    <= (w_state_nxt != IDLE) | w_pending_nxt;
            // Counted on entry to DONE so the count moves with the strobe.
            if (w_state_nxt == DONE) begin
                r_gen_count <= r_gen_count + GW'(1);
            end
        end
    end

    // New-field buffer: one row written per COMPUTE cycle, held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_field <= '0;
        end else if (w_row_we) begin
            r_field[r_row_idx] <= w_row_next;
        end
    end

    assign game_field_new     = r_field;
    assign new_game_field_vld = r_vld;
    assign busy               = r_busy;
    assign gen_count          = r_gen_count;

endmodule

// File: tb/tb_game_next_gen_engine.sv
// Directed bench for game_next_gen_engine: a table of single-generation
// vectors checked on a wrapping and a non-wrapping instance, plus
// hand-written multi-cycle sequences (queueing, reset abort, free run).
module tb_game_next_gen_engine;
    import game_pkg::*;

    localparam int H = FIELD_H;
    localparam int W = FIELD_W;

    logic        clk = 1'b0;
    logic        rst;
    logic        step_req;
    logic        load;
    field_t      drv;
    field_t      r_fld;
    field_t      new1, new0;
    logic        vld1, vld0, busy1, busy0;
    logic [15:0] gc1, gc0;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] exp_gc = 16'd0;
    field_t      cap1, cap0;

    always #5 clk = ~clk;

    // Downstream field register: latches the new field on the strobe.
    always @(posedge clk) begin
        if (load) r_fld <= drv;
        else if (vld1) r_fld <= new1;
    end

    game_next_gen_engine #(.W(W), .H(H), .WRAP(1), .GW(16)) dut_wrap (
        .clk(clk), .rst(rst), .step_req(step_req), .game_field_old(r_fld),
        .game_field_new(new1), .new_game_field_vld(vld1), .busy(busy1),
        .gen_count(gc1));

    game_next_gen_engine #(.W(W), .H(H), .WRAP(0), .GW(16)) dut_flat (
        .clk(clk), .rst(rst), .step_req(step_req), .game_field_old(r_fld),
        .game_field_new(new0), .new_game_field_vld(vld0), .busy(busy0),
        .gen_count(gc0));

    typedef struct {
        field_t init;
        field_t exp_wrap;
        field_t exp_flat;
    } vec_t;

    vec_t vecs[6];

    function automatic field_t put(input field_t f, input int r, input int c);
        field_t g = f;
        g[((r % H) + H) % H][((c % W) + W) % W] = 1'b1;
        return g;
    endfunction

    // Reference Conway step computed cell by cell with explicit neighbour scan.
    function automatic field_t golden(input field_t f, input bit wrap);
        field_t g = '0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                int n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr = r + dr;
                        int cc = c + dc;
                        if (dr == 0 && dc == 0) continue;
                        if (wrap) begin
                            rr = (rr + H) % H;
                            cc = (cc + W) % W;
                        end else if (rr < 0 || rr >= H || cc < 0 || cc >= W) begin
                            continue;
                        end
                        if (f[rr][cc]) n++;
                    end
                end
                g[r][c] = (n == 3) || (f[r][c] && n == 2);
            end
        end
        return g;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic chk_field(input string tag, input field_t act, input field_t exp);
        n_vec++;
        if (act !== exp) begin
            int fr = -1;
            int fc = -1;
            n_bad++;
            for (int r = H - 1; r >= 0; r--)
                for (int c = W - 1; c >= 0; c--)
                    if (act[r][c] !== exp[r][c]) begin fr = r; fc = c; end
            $display("FAIL %s: cell (%0d,%0d) got %b want %b", tag, fr, fc,
                     act[fr][fc], exp[fr][fc]);
        end
    endtask

    // One generation: optional load, single-cycle request, strobe expected in cycle 31.
    task automatic run_gen(input bit do_load, input field_t init, input string tag);
        int n;
        if (do_load) begin
            drv  = init;
            load = 1'b1;
            @(posedge clk); #1;
            load = 1'b0;
        end
        step_req = 1'b1;
        @(posedge clk); #1;
        step_req = 1'b0;
        n = 1;
        while (!vld1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " latency"}, n, 32'd31);
        chk({tag, " flat vld"}, {31'd0, vld0}, 32'd1);
        cap1 = new1;
        cap0 = new0;
        exp_gc++;
        @(posedge clk); #1;
        chk({tag, " vld single"}, {31'd0, vld1}, 32'd0);
        chk({tag, " gen_count"}, {16'd0, gc1}, {16'd0, exp_gc});
        chk({tag, " flat gen_count"}, {16'd0, gc0}, {16'd0, exp_gc});
    endtask

    initial begin
        field_t f, e, g;
        int     vc[$];
        int     bbad;
        int     ns;

        rst = 1'b1; step_req = 1'b0; load = 1'b0; drv = '0;
        // Vector table: hand-derived results for wrapping and flat edges.
        for (int i = 0; i < 6; i++) begin
            vecs[i].init = '0; vecs[i].exp_wrap = '0; vecs[i].exp_flat = '0;
        end
        // 1: blinker horizontal -> vertical
        vecs[1].init = put(put(put('0, 10, 5), 10, 6), 10, 7);
        vecs[1].exp_wrap = put(put(put('0, 9, 6), 10, 6), 11, 6);
        vecs[1].exp_flat = vecs[1].exp_wrap;
        // 2: block still life in the top-left corner
        vecs[2].init = put(put(put(put('0, 0, 0), 0, 1), 1, 0), 1, 1);
        vecs[2].exp_wrap = vecs[2].init;
        vecs[2].exp_flat = vecs[2].init;
        // 3: three corner cells around (0,0): birth only with wrap
        vecs[3].init = put(put(put('0, 0, 39), 29, 0), 29, 39);
        vecs[3].exp_wrap = put(vecs[3].init, 0, 0);
        // 4: blinker straddling the column seam
        vecs[4].init = put(put(put('0, 5, 39), 5, 0), 5, 1);
        vecs[4].exp_wrap = put(put(put('0, 4, 0), 5, 0), 6, 0);
        // 5: lone cell dies
        vecs[5].init = put('0, 15, 20);

        #12;
        chk("reset vld", {31'd0, vld1}, 32'd0);
        chk("reset busy", {31'd0, busy1}, 32'd0);
        chk("reset gen_count", {16'd0, gc1}, 32'd0);
        chk_field("reset buffer", new1, '0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_gen(1'b1, vecs[i].init, $sformatf("vec%0d", i));
            chk_field($sformatf("vec%0d wrap field", i), cap1, vecs[i].exp_wrap);
            chk_field($sformatf("vec%0d flat field", i), cap0, vecs[i].exp_flat);
        end

        // Glider across the (29,39) corner: four generations shift it by (+1,+1).
        f = put(put(put(put(put('0, 28, 39), 29, 40), 30, 38), 30, 39), 30, 40);
        e = put(put(put(put(put('0, 29, 40), 30, 41), 31, 39), 31, 40), 31, 41);
        g = f;
        for (int k = 0; k < 4; k++) begin
            run_gen(k == 0, f, $sformatf("glider g%0d", k + 1));
            g = golden(g, 1'b1);
            chk_field($sformatf("glider g%0d field", k + 1), cap1, g);
        end
        chk_field("glider shifted", cap1, e);

        // Requests at cycles 0, 5, 6: one queued, one dropped.
        drv = vecs[1].init; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        vc.delete(); bbad = 0;
        for (int c = 0; c <= 70; c++) begin
            if (vld1) begin vc.push_back(c); cap1 = new1; end
            if (busy1 !== ((c >= 1 && c <= 62) ? 1'b1 : 1'b0)) bbad++;
            step_req = (c == 0 || c == 5 || c == 6);
            @(posedge clk); #1;
        end
        step_req = 1'b0;
        exp_gc += 16'd2;
        chk("queue strobes", vc.size(), 32'd2);
        if (vc.size() >= 2) begin
            chk("queue strobe1", vc[0], 32'd31);
            chk("queue strobe2", vc[1], 32'd62);
        end
        chk("queue busy window errors", bbad, 32'd0);
        chk("queue gen_count", {16'd0, gc1}, {16'd0, exp_gc});
        chk_field("queue field", cap1, vecs[1].init);

        // Reset mid-compute aborts the generation without a strobe.
        drv = vecs[1].init; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        step_req = 1'b1;
        @(posedge clk); #1;
        step_req = 1'b0;
        ns = 0;
        for (int c = 1; c < 15; c++) begin
            if (vld1) ns++;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("abort busy", {31'd0, busy1}, 32'd0);
        chk("abort gen_count", {16'd0, gc1}, 32'd0);
        chk_field("abort buffer", new1, '0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        exp_gc = 16'd0;
        for (int c = 0; c < 60; c++) begin
            if (vld1 || vld0) ns++;
            @(posedge clk); #1;
        end
        chk("abort strobes", ns, 32'd0);
        chk("abort busy after", {31'd0, busy1}, 32'd0);
        run_gen(1'b1, vecs[1].init, "after abort");
        chk_field("after abort field", cap1, vecs[1].exp_wrap);

        // Continuous requests for 100 cycles with the field register closing the loop.
        f = put(put(put(put(put('0, 3, 4), 4, 5), 5, 3), 5, 4), 5, 5);
        f = put(put(put(f, 20, 29), 20, 30), 20, 31);
        f = put(put(put(put(f, 10, 20), 10, 21), 11, 20), 11, 21);
        drv = f; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        g = f; ns = 0;
        for (int c = 0; c < 200; c++) begin
            if (vld1) begin
                ns++;
                chk($sformatf("run strobe%0d cycle", ns), c, 31 * ns);
                g = golden(g, 1'b1);
                chk_field($sformatf("run gen%0d field", ns), new1, g);
            end
            step_req = (c < 100);
            @(posedge clk); #1;
        end
        step_req = 1'b0;
        chk("run strobe count", ns, 32'd5);
        chk("run busy drained", {31'd0, busy1}, 32'd0);
        chk("run gen_count", {16'd0, gc1}, {16'd0, exp_gc + 16'd5});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
